var_states_xfer: RTL and testbench

//   Writer/reader for the state-list load/update port (wr_states / vars_states_i / vars_states_o) of one bin.

---
 rtl/var_states_xfer_pkg.sv | 16 +
 rtl/var_states_xfer.sv | 140 ++++++++++++++
 tb/tb_var_states_xfer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/var_states_xfer_pkg.sv
// Shared sat-engine definitions: per-bin slot count and packed var-state word layout.
// The state list uses the same constants, so both sides agree on the packing.
package var_states_xfer_pkg;

  localparam int NUM_VARS         = 8;
  localparam int WIDTH_LVL        = 16;
  localparam int WIDTH_VAR_STATES = 3 + WIDTH_LVL;

  function automatic logic [WIDTH_VAR_STATES-1:0] pack_var_state(
    input logic [2:0]           value,
    input logic [WIDTH_LVL-1:0] lvl
  );
    return {value, lvl};
  endfunction

endpackage

// File: rtl/var_states_xfer.sv
// Moves one bin's packed var states between the global var-state RAM and the state list:
// LOAD reads NUM_VARS words then pulses wr_states_o, STORE snapshots the bin and writes it back.
module var_states_xfer
  import var_states_xfer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_store_i,
  input  logic [ADDR_W-1:0]                    bin_base_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 ram_rd_o,
  output logic                                 ram_we_o,
  output logic [ADDR_W-1:0]                    ram_addr_o,
  output logic [WIDTH_VAR_STATES-1:0]          ram_wdata_o,
  input  logic [WIDTH_VAR_STATES-1:0]          ram_rdata_i,
  output logic                                 wr_states_o,
  output logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vars_states_o,
  input  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vars_states_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_RD   = 3'd1;
  localparam logic [2:0] S_LD_LAST = 3'd2;
  localparam logic [2:0] S_LD_WR   = 3'd3;
  localparam logic [2:0] S_ST_WR   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    LD_RD   = S_LD_RD,
    LD_LAST = S_LD_LAST,
    LD_WR   = S_LD_WR,
    ST_WR   = S_ST_WR,
    DONE    = S_DONE
  } state_t;

  localparam int              CNT_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VARS - 1);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            base;
  logic [WIDTH_VAR_STATES-1:0]  slot [NUM_VARS];
  logic [CNT_W-1:0]             cnt_nxt;
  logic [CNT_W-1:0]             cnt_prv;

  assign cnt_nxt = cnt + 1'b1;
  assign cnt_prv = cnt - 1'b1;

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_pack
    assign vars_states_o[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] = slot[k];
  end

  // Read data lags ram_rd_o by one cycle, so LD_RD captures the previous read and LD_LAST the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      for (int k = 0; k < NUM_VARS; k++) slot[k] <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ram_rd_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      wr_states_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_load_i) begin
            state      <= LD_RD;
            busy_o     <= 1'b1;
            base       <= bin_base_i;
            cnt        <= '0;
            ram_rd_o   <= 1'b1;
            ram_addr_o <= bin_base_i;
          end else if (start_store_i) begin
            state       <= ST_WR;
            busy_o      <= 1'b1;
            base        <= bin_base_i;
            cnt         <= '0;
            for (int k = 0; k < NUM_VARS; k++)
              slot[k] <= vars_states_i[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
            ram_we_o    <= 1'b1;
            ram_addr_o  <= bin_base_i;
            ram_wdata_o <= vars_states_i[0 +: WIDTH_VAR_STATES];
          end
        end
        LD_RD: begin
          if (cnt != '0) slot[cnt_prv] <= ram_rdata_i;
          if (cnt == CNT_LAST) begin
            state      <= LD_LAST;
            ram_rd_o   <= 1'b0;
            ram_addr_o <= '0;
          end else begin
            cnt        <= cnt_nxt;
            ram_addr_o <= base + ADDR_W'(cnt_nxt);
          end
        end
        LD_LAST: begin
          slot[CNT_LAST] <= ram_rdata_i;
          wr_states_o    <= 1'b1;
          state          <= LD_WR;
        end
        LD_WR: begin
          wr_states_o <= 1'b0;
          done_o      <= 1'b1;
          state       <= DONE;
        end
        ST_WR: begin
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            done_o      <= 1'b1;
          end else begin
            cnt         <= cnt_nxt;
            ram_addr_o  <= base + ADDR_W'(cnt_nxt);
            ram_wdata_o <= slot[cnt_nxt];
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_var_states_xfer.sv
// Directed bench for var_states_xfer: a RAM model plus queues of expected reads, writes
// and wr_states_o vectors that a negedge monitor pops as the DUT produces them.
module tb_var_states_xfer;
  import var_states_xfer_pkg::*;

  localparam int ADDR_W = 10;
  localparam int W      = WIDTH_VAR_STATES;
  localparam int VEC_W  = NUM_VARS * W;
  localparam int CHK_W  = 256;

  logic              clk;
  logic              rst;
  logic              start_load_i;
  logic              start_store_i;
  logic [ADDR_W-1:0] bin_base_i;
  logic              busy_o;
  logic              done_o;
  logic              ram_rd_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [W-1:0]      ram_wdata_o;
  logic [W-1:0]      ram_rdata_i;
  logic              wr_states_o;
  logic [VEC_W-1:0]  vars_states_o;
  logic [VEC_W-1:0]  vars_states_i;

  int checks     = 0;
  int errors     = 0;
  int cycleNo    = 0;
  int startCycle = 0;
  int wrCycle    = -1;

  logic [ADDR_W-1:0]   rdQ [$];
  logic [ADDR_W+W-1:0] wrQ [$];
  logic [VEC_W-1:0]    wsQ [$];

  logic [W-1:0]      mem [1 << ADDR_W];
  logic              preWe;
  logic [ADDR_W-1:0] preAddr;
  logic [W-1:0]      preData;

  var_states_xfer #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_load_i  (start_load_i),
    .start_store_i (start_store_i),
    .bin_base_i    (bin_base_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .ram_rd_o      (ram_rd_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata_i),
    .wr_states_o   (wr_states_o),
    .vars_states_o (vars_states_o),
    .vars_states_i (vars_states_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // RAM model with one-cycle read latency and a backdoor preload port.
  always @(posedge clk) begin
    if (preWe) mem[preAddr] <= preData;
    else if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= ram_rd_o ? mem[ram_addr_o] : '0;
  end

  task automatic checkOutput(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CHK_W-1:0] allOutputs();
    return CHK_W'({busy_o, done_o, ram_rd_o, ram_we_o, ram_addr_o, ram_wdata_o, wr_states_o, vars_states_o});
  endfunction

  // Monitor: strobe exclusivity, idle address/data, and scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("strobe_excl", CHK_W'($countones({ram_rd_o, ram_we_o, wr_states_o}) <= 1), CHK_W'(1));
      if (!ram_rd_o && !ram_we_o)
        checkOutput("addr_wdata_idle", CHK_W'({ram_addr_o, ram_wdata_o}), '0);
      if (ram_rd_o) begin
        checkOutput("rd_expected", CHK_W'(rdQ.size() != 0), CHK_W'(1));
        if (rdQ.size() != 0) checkOutput("rd_addr", CHK_W'(ram_addr_o), CHK_W'(rdQ.pop_front()));
      end
      if (ram_we_o) begin
        checkOutput("we_expected", CHK_W'(wrQ.size() != 0), CHK_W'(1));
        if (wrQ.size() != 0) checkOutput("we_addr_data", CHK_W'({ram_addr_o, ram_wdata_o}), CHK_W'(wrQ.pop_front()));
      end
      if (wr_states_o) begin
        wrCycle = cycleNo - startCycle;
        checkOutput("ws_expected", CHK_W'(wsQ.size() != 0), CHK_W'(1));
        if (wsQ.size() != 0) checkOutput("ws_vector", CHK_W'(vars_states_o), CHK_W'(wsQ.pop_front()));
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] v);
    preWe = 1'b1;
    for (int k = 0; k < NUM_VARS; k++) begin
      preAddr = ADDR_W'(base + k);
      preData = v[k*W +: W];
      @(negedge clk);
    end
    preWe = 1'b0;
  endtask

  task automatic expectLoad(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] v);
    for (int k = 0; k < NUM_VARS; k++) rdQ.push_back(ADDR_W'(base + k));
    wsQ.push_back(v);
  endtask

  task automatic expectStore(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] v);
    for (int k = 0; k < NUM_VARS; k++) wrQ.push_back({ADDR_W'(base + k), v[k*W +: W]});
  endtask

  task automatic checkMem(input string tag, input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] v);
    for (int k = 0; k < NUM_VARS; k++)
      checkOutput(tag, CHK_W'(mem[ADDR_W'(base + k)]), CHK_W'(v[k*W +: W]));
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [ADDR_W-1:0] base,
                               input logic [VEC_W-1:0] vin);
    start_load_i  = ld;
    start_store_i = st;
    bin_base_i    = base;
    vars_states_i = vin;
    wrCycle       = -1;
    startCycle    = cycleNo;
    @(negedge clk);
    start_load_i  = 1'b0;
    start_store_i = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        cyc = cycleNo - startCycle;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [VEC_W-1:0] v;
    logic [VEC_W-1:0] vb;
    int               cyc;

    rst = 1'b0; start_load_i = 1'b0; start_store_i = 1'b0;
    bin_base_i = '0; vars_states_i = '0;
    preWe = 1'b0; preAddr = '0; preData = '0;
    #1 checkOutput("reset_outputs", allOutputs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: basic LOAD
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'b010, 16'(k + 1));
    preload(10'h010, v);
    expectLoad(10'h010, v);
    applyStimulus(1'b1, 1'b0, 10'h010, '0);
    checkOutput("t1_busy", CHK_W'(busy_o), CHK_W'(1));
    waitDone(cyc);
    checkOutput("t1_done_cycle", CHK_W'(cyc), CHK_W'(11));
    checkOutput("t1_ws_cycle", CHK_W'(wrCycle), CHK_W'(10));
    checkOutput("t1_reads_used", CHK_W'(rdQ.size()), '0);
    @(negedge clk);
    checkOutput("t1_idle", CHK_W'({busy_o, done_o}), '0);

    // 2: STORE with the bin changing after the snapshot
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'b100, 16'(3 * k));
    expectStore(10'h020, v);
    applyStimulus(1'b0, 1'b1, 10'h020, v);
    @(negedge clk);
    vars_states_i = ~v;
    waitDone(cyc);
    checkOutput("t2_done_cycle", CHK_W'(cyc), CHK_W'(9));
    checkMem("t2_mem", 10'h020, v);
    @(negedge clk);

    // 3: LOAD wrapping past the top of the RAM
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'(7 - k), 16'(16'hA000 + k));
    preload(10'h3FE, v);
    expectLoad(10'h3FE, v);
    applyStimulus(1'b1, 1'b0, 10'h3FE, '0);
    waitDone(cyc);
    checkOutput("t3_done_cycle", CHK_W'(cyc), CHK_W'(11));
    checkOutput("t3_reads_used", CHK_W'(rdQ.size()), '0);
    @(negedge clk);

    // 4: simultaneous starts, LOAD wins; a mid-transfer store is ignored
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'(k), 16'(k * k + 5));
    preload(10'h040, v);
    expectLoad(10'h040, v);
    applyStimulus(1'b1, 1'b1, 10'h040, ~v);
    repeat (3) @(negedge clk);
    start_store_i = 1'b1;
    @(negedge clk);
    start_store_i = 1'b0;
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      checkOutput("t4_busy", CHK_W'(busy_o), CHK_W'(1));
      if (done_o) begin
        cyc = cycleNo - startCycle;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t4_done_cycle", CHK_W'(cyc), CHK_W'(11));
    @(negedge clk);
    checkOutput("t4_idle_a", CHK_W'(busy_o), '0);
    @(negedge clk);
    checkOutput("t4_idle_b", CHK_W'(busy_o), '0);

    // 5: reset in cycle 5 of a LOAD aborts it; a fresh STORE then completes
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'b001, 16'(16'h0500 + k));
    preload(10'h050, v);
    for (int k = 0; k < 4; k++) rdQ.push_back(ADDR_W'(10'h050 + k));
    applyStimulus(1'b1, 1'b0, 10'h050, '0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("t5_reset_outputs", allOutputs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t5_quiet", CHK_W'({busy_o, done_o, wr_states_o}), '0);
    end
    checkOutput("t5_reads_used", CHK_W'(rdQ.size()), '0);
    for (int k = 0; k < NUM_VARS; k++) vb[k*W +: W] = pack_var_state(3'b110, 16'(16'h0600 + 7 * k));
    expectStore(10'h060, vb);
    applyStimulus(1'b0, 1'b1, 10'h060, vb);
    waitDone(cyc);
    checkOutput("t5_done_cycle", CHK_W'(cyc), CHK_W'(9));
    checkMem("t5_mem", 10'h060, vb);

    // 6: STORE accepted in the IDLE cycle right after LOAD's done_o
    @(negedge clk);
    for (int k = 0; k < NUM_VARS; k++) v[k*W +: W] = pack_var_state(3'b011, 16'(16'h0700 + k));
    preload(10'h070, v);
    expectLoad(10'h070, v);
    applyStimulus(1'b1, 1'b0, 10'h070, '0);
    waitDone(cyc);
    checkOutput("t6_load_done_cycle", CHK_W'(cyc), CHK_W'(11));
    @(negedge clk);
    checkOutput("t6_gap_idle", CHK_W'(busy_o), '0);
    for (int k = 0; k < NUM_VARS; k++) vb[k*W +: W] = pack_var_state(3'b101, 16'(16'h0800 + 3 * k));
    expectStore(10'h080, vb);
    applyStimulus(1'b0, 1'b1, 10'h080, vb);
    checkOutput("t6_store_busy", CHK_W'(busy_o), CHK_W'(1));
    waitDone(cyc);
    checkOutput("t6_store_done_cycle", CHK_W'(cyc), CHK_W'(9));
    checkMem("t6_mem", 10'h080, vb);
    @(negedge clk);

    checkOutput("queues_drained", CHK_W'({rdQ.size() == 0, wrQ.size() == 0, wsQ.size() == 0}), CHK_W'(3'b111));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
